// File: rtl/control_unit_if.sv
// rtl/control_unit_if.sv - SimpleCPU control interface: instruction memory, data memory and datapath control.
interface control_unit_if #(
   parameter int PC_W = 16
);
   logic [PC_W-1:0] I_addr;
   logic            I_rd;
   logic [15:0]     I_data;
   logic [7:0]      D_addr;
   logic            D_rd;
   logic            D_wr;
   logic            RF_s;
   logic [3:0]      RF_W_addr;
   logic            RF_W_wr;
   logic [3:0]      RF_Rp_addr;
   logic            RF_Rp_rd;
   logic [3:0]      RF_Rq_addr;
   logic            RF_Rq_rd;
   logic            alu_s0;
   logic [7:0]      Val_cons;
   logic            RF_cons;
   logic            RF_ext;
   logic            RF_Rp_zero;
   logic            halted;

   modport master (
      output I_addr, I_rd,
      input  I_data,
      output D_addr, D_rd, D_wr,
      output RF_s, RF_W_addr, RF_W_wr,
      output RF_Rp_addr, RF_Rp_rd, RF_Rq_addr, RF_Rq_rd,
      output alu_s0, Val_cons, RF_cons, RF_ext,
      input  RF_Rp_zero,
      output halted
   );

   modport slave (
      input  I_addr, I_rd,
      output I_data,
      input  D_addr, D_rd, D_wr,
      input  RF_s, RF_W_addr, RF_W_wr,
      input  RF_Rp_addr, RF_Rp_rd, RF_Rq_addr, RF_Rq_rd,
      input  alu_s0, Val_cons, RF_cons, RF_ext,
      output RF_Rp_zero,
      input  halted
   );
endinterface

// File: rtl/control_unit.sv
// rtl/control_unit.sv - SimpleCPU multi-cycle fetch/decode/execute controller.
// Optional HALT state for opcode 1111 is enabled by CONTROL_UNIT_HALT_EN.
module control_unit #(
   parameter int PC_W = 16
) (
   input  logic           clk,
   input  logic           rst,
   control_unit_if.master cu
);

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_LOAD,
      S_STORE,
      S_ADD,
      S_SUB,
      S_LOADC,
      S_LOADCN,
      S_JMPZ,
      S_JMPZ_TAKE,
      S_NOP
`ifdef CONTROL_UNIT_HALT_EN
      , S_HALT
`endif
   } state_t;

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [15:0]     ir_q, ir_d;

   logic [3:0]      opcode;
   logic [3:0]      ra, rb, rc;
   logic [7:0]      k;
   logic [PC_W-1:0] k_sext;

   assign opcode = ir_q[15:12];
   assign ra     = ir_q[11:8];
   assign rb     = ir_q[7:4];
   assign rc     = ir_q[3:0];
   assign k      = ir_q[7:0];
   assign k_sext = {{(PC_W-8){k[7]}}, k};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         pc_q    <= '0;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      case (state_q)
         S_FETCH: begin
            ir_d    = cu.I_data;
            pc_d    = pc_q + PC_W'(1);
            state_d = S_DECODE;
         end
         S_DECODE: begin
            case (opcode)
               4'h0:    state_d = S_LOAD;
               4'h1:    state_d = S_STORE;
               4'h2:    state_d = S_ADD;
               4'h3:    state_d = S_LOADC;
               4'h4:    state_d = S_SUB;
               4'h5:    state_d = S_JMPZ;
               4'h6:    state_d = S_LOADCN;
`ifdef CONTROL_UNIT_HALT_EN
               4'hF:    state_d = S_HALT;
`endif
               default: state_d = S_NOP;
            endcase
         end
         S_JMPZ: begin
            state_d = cu.RF_Rp_zero ? S_JMPZ_TAKE : S_FETCH;
         end
         S_JMPZ_TAKE: begin
            // PC already points past the JMPZ, so back off by one to land on JMPZ address + k.
            pc_d    = pc_q + k_sext - PC_W'(1);
            state_d = S_FETCH;
         end
`ifdef CONTROL_UNIT_HALT_EN
         S_HALT: begin
            state_d = S_HALT;
         end
`endif
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   // Outputs are forced low while rst is high so an aborted instruction cannot write.
   always_comb begin
      cu.I_addr     = '0;
      cu.I_rd       = 1'b0;
      cu.D_addr     = '0;
      cu.D_rd       = 1'b0;
      cu.D_wr       = 1'b0;
      cu.RF_s       = 1'b0;
      cu.RF_W_addr  = '0;
      cu.RF_W_wr    = 1'b0;
      cu.RF_Rp_addr = '0;
      cu.RF_Rp_rd   = 1'b0;
      cu.RF_Rq_addr = '0;
      cu.RF_Rq_rd   = 1'b0;
      cu.alu_s0     = 1'b0;
      cu.Val_cons   = '0;
      cu.RF_cons    = 1'b0;
      cu.RF_ext     = 1'b0;
      cu.halted     = 1'b0;
      if (!rst) begin
         case (state_q)
            S_FETCH: begin
               cu.I_addr = pc_q;
               cu.I_rd   = 1'b1;
            end
            S_LOAD: begin
               cu.D_addr    = k;
               cu.D_rd      = 1'b1;
               cu.RF_s      = 1'b1;
               cu.RF_W_addr = ra;
               cu.RF_W_wr   = 1'b1;
            end
            S_STORE: begin
               cu.D_addr     = k;
               cu.D_wr       = 1'b1;
               cu.RF_Rp_addr = ra;
               cu.RF_Rp_rd   = 1'b1;
            end
            S_ADD, S_SUB: begin
               cu.RF_Rp_addr = rb;
               cu.RF_Rp_rd   = 1'b1;
               cu.RF_Rq_addr = rc;
               cu.RF_Rq_rd   = 1'b1;
               cu.alu_s0     = (state_q == S_SUB);
               cu.RF_W_addr  = ra;
               cu.RF_W_wr    = 1'b1;
            end
            S_LOADC, S_LOADCN: begin
               cu.Val_cons  = k;
               cu.RF_cons   = 1'b1;
               cu.RF_ext    = (state_q == S_LOADCN);
               cu.RF_W_addr = ra;
               cu.RF_W_wr   = 1'b1;
            end
            S_JMPZ: begin
               cu.RF_Rp_addr = ra;
               cu.RF_Rp_rd   = 1'b1;
            end
`ifdef CONTROL_UNIT_HALT_EN
            S_HALT: begin
               cu.halted = 1'b1;
            end
`endif
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed bench for control_unit with memory and datapath models.
module tb_control_unit;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   control_unit_if #(.PC_W(16)) cu ();

   control_unit #(.PC_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .cu  (cu.master)
   );

   logic [15:0] imem [0:255];
   logic [15:0] dmem [0:255];
   logic [15:0] rf   [0:15];
   logic        init_req = 1'b0;
   logic [15:0] r0_init  = 16'h0000;

   int n_cmp = 0;
   int n_err = 0;

   // Strobe vector: I_rd D_rd D_wr RF_s RF_W_wr RF_Rp_rd RF_Rq_rd alu_s0 RF_cons RF_ext halted
   logic [10:0] strobes;
   assign strobes = {cu.I_rd, cu.D_rd, cu.D_wr, cu.RF_s, cu.RF_W_wr, cu.RF_Rp_rd,
                     cu.RF_Rq_rd, cu.alu_s0, cu.RF_cons, cu.RF_ext, cu.halted};

   assign cu.I_data     = imem[cu.I_addr[7:0]];
   assign cu.RF_Rp_zero = (rf[cu.RF_Rp_addr] == 16'h0000);

   logic [15:0] alu_res, wb_val, wb_pre;
   always_comb begin
      alu_res = cu.alu_s0 ? rf[cu.RF_Rp_addr] - rf[cu.RF_Rq_addr]
                          : rf[cu.RF_Rp_addr] + rf[cu.RF_Rq_addr];
      wb_pre  = cu.RF_cons ? {8'h00, cu.Val_cons} : (cu.RF_s ? dmem[cu.D_addr] : alu_res);
      wb_val  = cu.RF_ext ? (16'h0000 - wb_pre) : wb_pre;
   end

   always @(posedge clk) begin
      if (init_req) begin
         for (int i = 0; i < 16; i++) rf[i] <= (i == 0) ? r0_init : 16'h0000;
         for (int i = 0; i < 256; i++) dmem[i] <= 16'h0000;
         dmem[8'h10] <= 16'h1234;
      end else begin
         if (cu.RF_W_wr) rf[cu.RF_W_addr] <= wb_val;
         if (cu.D_wr) dmem[cu.D_addr] <= rf[cu.RF_Rp_addr];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(negedge clk);
      #1;
   endtask

   task automatic fill_nop();
      for (int i = 0; i < 256; i++) imem[i] = 16'h7000;
   endtask

   task automatic do_reset(input logic [15:0] r0);
      r0_init  = r0;
      rst      = 1'b1;
      init_req = 1'b1;
      nxt();
      nxt();
      init_req = 1'b0;
      check("reset_strobes", 32'(strobes), 32'h000);
      check("reset_iaddr", 32'(cu.I_addr), 32'h0000);
      @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   task automatic wait_fetch(input logic [15:0] addr, input string tag);
      int n = 0;
      while (!(cu.I_rd === 1'b1 && cu.I_addr === addr) && n < 100) begin
         nxt();
         n++;
      end
      check(tag, 32'(cu.I_addr), 32'(addr));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Straight-line program: LOADC, LOADCN, LOAD, ADD, SUB, STORE, NOP
      fill_nop();
      imem[0] = 16'h3A05;
      imem[1] = 16'h6203;
      imem[2] = 16'h0110;
      imem[3] = 16'h2311;
      imem[4] = 16'h4431;
      imem[5] = 16'h1420;
      do_reset(16'h0000);
      check("c1_fetch_strobes", 32'(strobes), 32'h400);
      check("c1_fetch_addr", 32'(cu.I_addr), 32'h0);
      nxt();
      check("c2_decode_strobes", 32'(strobes), 32'h000);
      nxt();
      check("loadc_strobes", 32'(strobes), 32'h044);
      check("loadc_cons", 32'(cu.Val_cons), 32'h05);
      check("loadc_waddr", 32'(cu.RF_W_addr), 32'd10);
      nxt();
      check("c4_fetch_addr", 32'(cu.I_addr), 32'h1);
      check("c4_fetch_strobes", 32'(strobes), 32'h400);
      check("r10", 32'(rf[10]), 32'h0005);
      nxt();
      nxt();
      check("loadcn_strobes", 32'(strobes), 32'h046);
      check("loadcn_cons_waddr", {cu.Val_cons, cu.RF_W_addr}, 32'h032);
      nxt();
      check("r2", 32'(rf[2]), 32'hFFFD);
      check("c7_fetch_addr", 32'(cu.I_addr), 32'h2);
      nxt();
      nxt();
      check("load_strobes", 32'(strobes), 32'h2C0);
      check("load_daddr_waddr", {cu.D_addr, cu.RF_W_addr}, 32'h101);
      nxt();
      check("r1", 32'(rf[1]), 32'h1234);
      nxt();
      nxt();
      check("add_strobes", 32'(strobes), 32'h070);
      check("add_addrs", {cu.RF_Rp_addr, cu.RF_Rq_addr, cu.RF_W_addr}, 32'h113);
      nxt();
      check("r3", 32'(rf[3]), 32'h2468);
      nxt();
      nxt();
      check("sub_strobes", 32'(strobes), 32'h078);
      check("sub_addrs", {cu.RF_Rp_addr, cu.RF_Rq_addr, cu.RF_W_addr}, 32'h314);
      nxt();
      check("r4", 32'(rf[4]), 32'h1234);
      nxt();
      nxt();
      check("store_strobes", 32'(strobes), 32'h120);
      check("store_daddr_rp", {cu.D_addr, cu.RF_Rp_addr}, 32'h204);
      nxt();
      check("post_store_strobes", 32'(strobes), 32'h400);
      check("d20", 32'(dmem[8'h20]), 32'h1234);
      check("c19_fetch_addr", 32'(cu.I_addr), 32'h6);
      nxt();
      nxt();
      check("nop_strobes", 32'(strobes), 32'h000);
      nxt();
      check("c22_fetch_addr", 32'(cu.I_addr), 32'h7);

      // Taken JMPZ: R0 = 0, k = -2 from address 5 lands on 3
      fill_nop();
      imem[5] = 16'h50FE;
      imem[6] = 16'h2300;
      do_reset(16'h0000);
      wait_fetch(16'h5, "jz_reach5");
      nxt();
      nxt();
      check("jmpz_strobes", 32'(strobes), 32'h020);
      check("jmpz_rp_addr", 32'(cu.RF_Rp_addr), 32'h0);
      nxt();
      check("jmpz_take_strobes", 32'(strobes), 32'h000);
      nxt();
      check("jz_target_addr", 32'(cu.I_addr), 32'h3);
      check("jz_target_strobes", 32'(strobes), 32'h400);
      wait_fetch(16'h5, "jz_loop_back");

      // Not-taken JMPZ: R0 = 7, then reset during ADD execute
      do_reset(16'h0007);
      wait_fetch(16'h5, "jnz_reach5");
      nxt();
      nxt();
      check("jnz_strobes", 32'(strobes), 32'h020);
      nxt();
      check("jnz_next_addr", 32'(cu.I_addr), 32'h6);
      check("jnz_next_strobes", 32'(strobes), 32'h400);
      nxt();
      nxt();
      check("add_exec_strobes", 32'(strobes), 32'h070);
      rst = 1'b1;
      #1;
      check("rst_mid_strobes", 32'(strobes), 32'h000);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_mid_fetch_addr", 32'(cu.I_addr), 32'h0);
      check("rst_mid_fetch_strobes", 32'(strobes), 32'h400);
      check("rst_mid_r3_unwritten", 32'(rf[3]), 32'h0000);

      // Opcode 1111 at address 2
      fill_nop();
      imem[2] = 16'hF000;
      do_reset(16'h0000);
      wait_fetch(16'h2, "f_reach2");
      nxt();
      nxt();
`ifdef CONTROL_UNIT_HALT_EN
      check("halt_strobes", 32'(strobes), 32'h001);
      for (int i = 0; i < 20; i++) begin
         nxt();
         check("halt_hold", 32'(strobes), 32'h001);
      end
`else
      check("f_nop_strobes", 32'(strobes), 32'h000);
      nxt();
      check("f_nop_next_addr", 32'(cu.I_addr), 32'h3);
      nxt();
      nxt();
      nxt();
      check("f_nop_pc4", 32'(cu.I_addr), 32'h4);
      check("f_nop_pc4_strobes", 32'(strobes), 32'h400);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multi-cycle FSM controller for the SimpleCPU. It is the driving end of the datapath control interface.
- Fetches 16-bit instructions from instruction memory and decodes them.
- Sequences register-file, ALU, constant and negate selects into the datapath, plus data-memory read/write strobes.
- Consumes the datapath zero flag for conditional jumps.

Parameters:
- PC_W, 16, program counter / instruction address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- I_addr  out  PC_W  instruction memory address (equals PC).
- I_rd  out  1  instruction memory read enable.
- I_data  in  16  instruction word; combinational read, valid in the same cycle as I_rd.
- D_addr  out  8  data memory address.
- D_rd  out  1  data memory read enable (memory drives datapath DM_Din combinationally).
- D_wr  out  1  data memory write enable; write data is datapath Rp_data.
- RF_s  out  1  write-back select: 1 = DM_Din, 0 = ALU result.
- RF_W_addr  out  4  register file write address.
- RF_W_wr  out  1  register file write enable.
- RF_Rp_addr  out  4  read port P address.
- RF_Rp_rd  out  1  read port P enable.
- RF_Rq_addr  out  4  read port Q address.
- RF_Rq_rd  out  1  read port Q enable.
- alu_s0  out  1  ALU op: 0 = A+B, 1 = A-B.
- Val_cons  out  8  constant to datapath (zero-extended there).
- RF_cons  out  1  write-back select: constant.
- RF_ext  out  1  negate write-back value (two's complement).
- RF_Rp_zero  in  1  1 when Rp_data == 0.
- halted  out  1  processor stopped; see Optional Feature.

Behaviour:
- Registers: PC[PC_W-1:0], IR[15:0], state.
- Reset: while rst=1 at a clk edge, PC<=0, IR<=0, state<=FETCH. All outputs are 0 during and immediately after reset, except I_addr=0 and I_rd, which follow FETCH on the first post-reset cycle. A reset mid-instruction aborts it; no partial write is retried.
- Outputs are Moore decodes of state and IR. Every output not listed for a state is 0.
- FETCH:
  - I_addr=PC, I_rd=1.
  - Edge: IR<=I_data, PC<=PC+1 (wraps modulo 2^PC_W).
  - Next: DECODE.
- DECODE: no outputs. Next state by IR[15:12]:
  - 0000 LOAD
  - 0001 STORE
  - 0010 ADD
  - 0011 LOADC
  - 0100 SUB
  - 0101 JMPZ
  - 0110 LOADCN
  - others NOP
- Field names: ra=IR[11:8], rb=IR[7:4], rc=IR[3:0], k=IR[7:0].
- LOAD (RF[ra]<=D[k]): D_addr=k, D_rd=1, RF_s=1, RF_W_addr=ra, RF_W_wr=1.
- STORE (D[k]<=RF[ra]): D_addr=k, D_wr=1, RF_Rp_addr=ra, RF_Rp_rd=1.
- ADD (RF[ra]<=RF[rb]+RF[rc]): RF_Rp_addr=rb, RF_Rp_rd=1, RF_Rq_addr=rc, RF_Rq_rd=1, alu_s0=0, RF_s=0, RF_W_addr=ra, RF_W_wr=1.
- SUB: as ADD but alu_s0=1. Result is modulo 2^16.
- LOADC (RF[ra]<=zext(k)): Val_cons=k, RF_cons=1, RF_W_addr=ra, RF_W_wr=1.
- LOADCN (RF[ra]<=-zext(k)): as LOADC plus RF_ext=1. k=0 writes 0.
- JMPZ:
  - RF_Rp_addr=ra, RF_Rp_rd=1.
  - Next state JMPZ_TAKE if RF_Rp_zero=1, else FETCH.
- JMPZ_TAKE:
  - PC<=PC+sext(k)-1, i.e. target = JMPZ address + signed k, modulo 2^PC_W.
  - Next: FETCH.
- NOP: no writes; next FETCH.
- LOAD, STORE, ADD, SUB, LOADC and LOADCN return to FETCH after one cycle.
- Latency:
  - 3 cycles per instruction.
  - 4 cycles for a taken JMPZ.
  - Never two writes (RF or DM) in one cycle.
- Self-loop JMPZ with k=0 and a zero register spins forever (legal).

Optional Feature:
- Macro: CONTROL_UNIT_HALT_EN.
- Defined:
  - Opcode 1111 in DECODE goes to HALT.
  - HALT drives no enables, holds PC, sets halted=1, and stays until rst.
- Undefined:
  - 1111 is a NOP.
  - No HALT state exists; halted is tied 0.

Test Plan:
- Reset then IMEM[0]=0x3A05 (LOADC R10,5) -> cycle 3: RF_cons=1, Val_cons=0x05, RF_W_addr=10, RF_W_wr=1; PC=1; FETCH on cycle 4.
- IMEM[1]=0x6203 (LOADCN R2,3) -> RF_cons=1, RF_ext=1, RF_W_addr=2; bench RF model holds R2=0xFFFD.
- LOAD R1,D[0x10] with D[0x10]=0x1234; ADD R3,R1,R1 (0x2311) -> R3=0x2468. SUB R4,R3,R1 (0x4431) -> alu_s0=1, R4=0x1234. STORE R4,D[0x20] (0x1420) -> D_wr=1 one cycle, D_addr=0x20, D[0x20]=0x1234.
- JMPZ at PC=5:
  - R0=0, word 0x50FE -> JMPZ_TAKE, next I_addr=3.
  - R0=7 -> no jump, next I_addr=6, 3 cycles total.
- Assert rst during an ADD execute cycle -> RF_W_wr=0 on that edge, PC=0, next cycle FETCH with I_addr=0.
- With CONTROL_UNIT_HALT_EN, 0xF000 at PC=2 -> halted=1, I_rd=0, PC stays 3 for 20 cycles. Without the macro: NOP, PC advances to 4.
